// File: rtl/plic_target_ctx.sv
// PLIC per-target context: threshold compare, external-interrupt line, claim/complete
// handshake and the in-service mask fed back to the gateways/arbiter.
module plic_target_ctx #(
  parameter int NUM_IRQ  = 32,
  parameter int ID_BASE  = 32,
  parameter int PRIO_BIT = 5,
  parameter int ID_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                irq_i,
  input  logic [ID_WIDTH-1:0] irq_id_i,
  input  logic [PRIO_BIT-1:0] irq_pri_i,
  input  logic [PRIO_BIT-1:0] threshold_i,
  input  logic                claim_req_i,
  input  logic                complete_req_i,
  input  logic [ID_WIDTH-1:0] complete_id_i,
  output logic                ready_o,
  output logic                claim_ack_o,
  output logic [ID_WIDTH-1:0] claim_id_o,
  output logic                complete_ack_o,
  output logic                eip_o,
  output logic [NUM_IRQ-1:0]  in_service_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CLAIM_RSP = 2'd1;
  localparam logic [1:0] CMPL_RSP  = 2'd2;

  // Range bounds carry one extra bit so ID_BASE+NUM_IRQ may equal 2**ID_WIDTH.
  localparam int                ID_END = ID_BASE + NUM_IRQ;
  localparam logic [ID_WIDTH:0] ID_LO  = (ID_WIDTH+1)'(ID_BASE);
  localparam logic [ID_WIDTH:0] ID_HI  = (ID_WIDTH+1)'(ID_END);
  localparam logic [ID_WIDTH-1:0] ID_OFS = ID_WIDTH'(ID_BASE);

  function automatic logic in_range(input logic [ID_WIDTH-1:0] id);
    return ({1'b0, id} >= ID_LO) && ({1'b0, id} < ID_HI);
  endfunction

  logic [1:0]          state_reg;
  logic                claim_elig_reg;
  logic [ID_WIDTH-1:0] claim_id_reg;
  logic [ID_WIDTH-1:0] cmpl_id_reg;
  logic                deferred_reg;
  logic                eip_reg;
  logic [NUM_IRQ-1:0]  in_service_reg;
  logic [NUM_IRQ-1:0]  in_service_next;

  logic                eligible;
  logic                claim_hit;
  logic                cmpl_hit;
  logic [ID_WIDTH-1:0] claim_idx;
  logic [ID_WIDTH-1:0] cmpl_idx;

  assign eligible  = irq_i && (irq_pri_i > threshold_i);
  assign claim_idx = claim_id_reg - ID_OFS;
  assign cmpl_idx  = cmpl_id_reg - ID_OFS;
  assign claim_hit = (state_reg == CLAIM_RSP) && claim_elig_reg && in_range(claim_id_reg);
  assign cmpl_hit  = (state_reg == CMPL_RSP) && in_range(cmpl_id_reg);

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_isv
      assign in_service_next[gi] =
        (in_service_reg[gi] | (claim_hit && (claim_idx == ID_WIDTH'(gi))))
        & ~(cmpl_hit && (cmpl_idx == ID_WIDTH'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      claim_elig_reg <= 1'b0;
      claim_id_reg   <= '0;
      cmpl_id_reg    <= '0;
      deferred_reg   <= 1'b0;
      eip_reg        <= 1'b0;
      in_service_reg <= '0;
    end else begin
      eip_reg        <= eligible;
      in_service_reg <= in_service_next;
      case (state_reg)
        IDLE: begin
          if (claim_req_i) begin
            state_reg      <= CLAIM_RSP;
            claim_elig_reg <= eligible;
            claim_id_reg   <= eligible ? irq_id_i : '0;
            // The hart is about to take this interrupt; drop the line while it responds.
            eip_reg        <= 1'b0;
            if (complete_req_i) begin
              cmpl_id_reg  <= complete_id_i;
              deferred_reg <= 1'b1;
            end
          end else if (complete_req_i) begin
            state_reg   <= CMPL_RSP;
            cmpl_id_reg <= complete_id_i;
          end
        end
        CLAIM_RSP: state_reg <= deferred_reg ? CMPL_RSP : IDLE;
        CMPL_RSP: begin
          deferred_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Acks are masked by rst so a transaction interrupted by reset never signals completion.
  assign ready_o        = (state_reg == IDLE) && !deferred_reg;
  assign claim_ack_o    = (state_reg == CLAIM_RSP) && !rst;
  assign complete_ack_o = (state_reg == CMPL_RSP) && !rst;
  assign claim_id_o     = claim_id_reg;
  assign eip_o          = eip_reg;
  assign in_service_o   = in_service_reg;

endmodule

// File: tb/tb_plic_target_ctx.sv
// Randomized bench for plic_target_ctx against a transaction-level model of the
// claim/complete protocol and the in-service set.
module tb_plic_target_ctx;

  localparam int NUM_IRQ  = 32;
  localparam int ID_BASE  = 32;
  localparam int PRIO_BIT = 5;
  localparam int ID_WIDTH = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                irq_i;
  logic [ID_WIDTH-1:0] irq_id_i;
  logic [PRIO_BIT-1:0] irq_pri_i;
  logic [PRIO_BIT-1:0] threshold_i;
  logic                claim_req_i;
  logic                complete_req_i;
  logic [ID_WIDTH-1:0] complete_id_i;
  logic                ready_o;
  logic                claim_ack_o;
  logic [ID_WIDTH-1:0] claim_id_o;
  logic                complete_ack_o;
  logic                eip_o;
  logic [NUM_IRQ-1:0]  in_service_o;

  int checks = 0;
  int errors = 0;
  logic [NUM_IRQ-1:0] m_isv;

  plic_target_ctx #(
    .NUM_IRQ(NUM_IRQ), .ID_BASE(ID_BASE), .PRIO_BIT(PRIO_BIT), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .irq_id_i(irq_id_i), .irq_pri_i(irq_pri_i),
    .threshold_i(threshold_i), .claim_req_i(claim_req_i), .complete_req_i(complete_req_i),
    .complete_id_i(complete_id_i), .ready_o(ready_o), .claim_ack_o(claim_ack_o),
    .claim_id_o(claim_id_o), .complete_ack_o(complete_ack_o), .eip_o(eip_o),
    .in_service_o(in_service_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input int id);
    return (id >= ID_BASE) && (id < ID_BASE + NUM_IRQ);
  endfunction

  // Complete: an in-range ID leaves the in-service set, anything else is ignored.
  function automatic void model_complete(input int id);
    if (in_rng(id)) m_isv[id - ID_BASE] = 1'b0;
  endfunction

  task automatic do_idle(input logic irq, input int pri, input int thr);
    irq_i = irq; irq_pri_i = PRIO_BIT'(pri); threshold_i = PRIO_BIT'(thr);
    tick();
    chk("idle_eip", eip_o, (irq && pri > thr) ? 1 : 0);
    chk("idle_cack", claim_ack_o, 0);
    chk("idle_kack", complete_ack_o, 0);
    chk("idle_ready", ready_o, 1);
    $display("idle irq=%0d pri=%0d thr=%0d eip=%0d", irq, pri, thr, eip_o);
  endtask

  task automatic do_claim(input logic irq, input int id, input int pri, input int thr,
                          input bit with_cmpl, input int cid);
    bit el;
    int exp_id;
    el = irq && (pri > thr);
    exp_id = el ? id : 0;
    irq_i = irq; irq_id_i = ID_WIDTH'(id); irq_pri_i = PRIO_BIT'(pri);
    threshold_i = PRIO_BIT'(thr);
    claim_req_i = 1'b1; complete_req_i = with_cmpl; complete_id_i = ID_WIDTH'(cid);
    chk("clm_ready_pre", ready_o, 1);
    tick();
    claim_req_i = 1'b0; complete_req_i = 1'b0;
    chk("clm_ack", claim_ack_o, 1);
    chk("clm_id", claim_id_o, exp_id);
    chk("clm_ready_busy", ready_o, 0);
    chk("clm_eip_forced", eip_o, 0);
    chk("clm_no_kack", complete_ack_o, 0);
    if (el && in_rng(id)) m_isv[id - ID_BASE] = 1'b1;
    tick();
    chk("clm_ack_end", claim_ack_o, 0);
    chk("clm_isv", in_service_o, m_isv);
    chk("clm_id_held", claim_id_o, exp_id);
    if (with_cmpl) begin
      chk("dfr_kack", complete_ack_o, 1);
      chk("dfr_ready_busy", ready_o, 0);
      model_complete(cid);
      tick();
      chk("dfr_kack_end", complete_ack_o, 0);
      chk("dfr_isv", in_service_o, m_isv);
    end
    chk("clm_ready_post", ready_o, 1);
    chk("clm_eip_post", eip_o, el ? 1 : 0);
    $display("claim irq=%0d id=%0d pri=%0d thr=%0d cmpl=%0d cid=%0d -> id=%0d isv=%08h",
             irq, id, pri, thr, with_cmpl, cid, claim_id_o, in_service_o);
  endtask

  task automatic do_complete(input int cid);
    complete_req_i = 1'b1; complete_id_i = ID_WIDTH'(cid);
    chk("cmp_ready_pre", ready_o, 1);
    tick();
    complete_req_i = 1'b0;
    chk("cmp_ack", complete_ack_o, 1);
    chk("cmp_ready_busy", ready_o, 0);
    chk("cmp_no_cack", claim_ack_o, 0);
    model_complete(cid);
    tick();
    chk("cmp_ack_end", complete_ack_o, 0);
    chk("cmp_isv", in_service_o, m_isv);
    chk("cmp_ready_post", ready_o, 1);
    $display("complete id=%0d isv=%08h", cid, in_service_o);
  endtask

  // Pick a source the arbiter could legally offer (not already in service); -1 if none.
  function automatic int free_id();
    int start;
    start = $urandom_range(NUM_IRQ - 1);
    for (int k = 0; k < NUM_IRQ; k++)
      if (!m_isv[(start + k) % NUM_IRQ]) return ID_BASE + (start + k) % NUM_IRQ;
    return -1;
  endfunction

  function automatic int busy_id();
    int start;
    start = $urandom_range(NUM_IRQ - 1);
    for (int k = 0; k < NUM_IRQ; k++)
      if (m_isv[(start + k) % NUM_IRQ]) return ID_BASE + (start + k) % NUM_IRQ;
    return -1;
  endfunction

  initial begin
    int op, id, cid, pri, thr;
    rst = 1'b1; irq_i = 0; irq_id_i = 0; irq_pri_i = 0; threshold_i = 0;
    claim_req_i = 0; complete_req_i = 0; complete_id_i = 0;
    m_isv = '0;
    tick(); tick();
    chk("rst_ready", ready_o, 1);
    chk("rst_cack", claim_ack_o, 0);
    chk("rst_kack", complete_ack_o, 0);
    chk("rst_cid", claim_id_o, 0);
    chk("rst_eip", eip_o, 0);
    chk("rst_isv", in_service_o, 0);
    rst = 1'b0;
    tick();

    // Directed scenarios.
    irq_id_i = 6'd40;
    do_idle(1'b1, 10, 5);
    do_claim(1'b1, 40, 10, 5, 1'b0, 0);
    chk("t1_isv8", in_service_o[8], 1);
    do_idle(1'b1, 8, 8);
    do_claim(1'b1, 41, 8, 8, 1'b0, 0);
    do_claim(1'b1, 42, 0, 0, 1'b0, 0);
    do_complete(40);
    chk("t3_isv8", in_service_o[8], 0);
    do_claim(1'b1, 40, 10, 5, 1'b0, 0);
    do_complete(5);
    do_complete(0);   // 64 aliases to 0 in a 6-bit ID field
    chk("t4_isv8_kept", in_service_o[8], 1);
    do_claim(1'b1, 55, 20, 3, 1'b1, 40);
    chk("t5_isv23", in_service_o[23], 1);
    chk("t5_isv8", in_service_o[8], 0);
    do_claim(1'b1, 63, 31, 30, 1'b0, 0);
    do_claim(1'b1, 32, 1, 0, 1'b0, 0);
    do_complete(63);
    do_complete(32);
    do_complete(31);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(3);
      pri = $urandom_range(31);
      thr = $urandom_range(31);
      case (op)
        0: do_idle(1'($urandom_range(1)), pri, thr);
        1, 3: begin
          id = free_id();
          cid = busy_id();
          if ($urandom_range(3) == 0 || cid < 0) cid = $urandom_range(63);
          if (id < 0) do_claim(1'b0, $urandom_range(63), pri, thr, op == 3, cid);
          else do_claim(1'($urandom_range(7) != 0), id, pri, thr, op == 3, cid);
        end
        default: begin
          cid = busy_id();
          if ($urandom_range(3) == 0 || cid < 0) cid = $urandom_range(63);
          do_complete(cid);
        end
      endcase
    end

    // Reset while the claim response is pending.
    irq_i = 1'b1; irq_id_i = 6'd41; irq_pri_i = 5'd9; threshold_i = 5'd1;
    claim_req_i = 1'b1;
    tick();
    claim_req_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_no_cack", claim_ack_o, 0);
    tick();
    rst = 1'b0;
    m_isv = '0;
    chk("t6_isv", in_service_o, m_isv);
    chk("t6_ready", ready_o, 1);
    chk("t6_cack", claim_ack_o, 0);
    chk("t6_cid", claim_id_o, 0);
    chk("t6_eip", eip_o, 0);
    tick();
    chk("t6_cack_after", claim_ack_o, 0);
    $display("reset during claim response isv=%08h", in_service_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
